// File: rtl/mem_responder.sv
// Memory-side responder for the cache refill/write interface: 4-beat line reads, single-word writes.
// Optional `MEM_PROTOCOL_CHECK_EN adds a sticky protocol-error flag on err_mem2cc.
module mem_responder #(
    parameter int                    ADR_WIDTH    = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    WORD_OFFSET  = 2,
    parameter int                    MEM_ADR_BITS = 6,
    parameter int                    LATENCY      = 2,
    parameter logic [DATA_WIDTH-1:0] SEED         = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_cc2mem,
    input  logic                   rdwr_cc2mem,
    input  logic [ADR_WIDTH-1:0]   adr_cc2mem,
    input  logic [DATA_WIDTH-1:0]  dat_cc2mem,
    output logic                   ack_mem2cc,
    output logic [DATA_WIDTH-1:0]  dat_mem2cc,
    output logic [WORD_OFFSET-1:0] word_mem2cc,
    output logic                   err_mem2cc
);

    localparam int DEPTH = 1 << MEM_ADR_BITS;
    localparam logic [ADR_WIDTH-1:0] LINE_MASK =
        ~((ADR_WIDTH'(1'b1) << (WORD_OFFSET + 2)) - ADR_WIDTH'(1'b1));
    localparam logic [WORD_OFFSET-1:0] LAST_BEAT = {WORD_OFFSET{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_BEAT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [3:0]              cnt_r, cnt_s;
    logic [WORD_OFFSET-1:0]  beat_r, beat_s;
    logic                    accept_s;
    logic [ADR_WIDTH-1:0]    adr_r;
    logic                    rdwr_r;
    logic [DATA_WIDTH-1:0]   wdat_r;
    logic                    ack_r, ack_s;
    logic [DATA_WIDTH-1:0]   rdat_r, rdat_s;
    logic [WORD_OFFSET-1:0]  word_r, word_s;
    logic [DEPTH-1:0]        valid_r;
    logic [DATA_WIDTH-1:0]   ram_r [DEPTH];

    logic                    rdwr_eff_s;
    logic [ADR_WIDTH-1:0]    adr_eff_s;
    logic [ADR_WIDTH-1:0]    beat_adr_s;
    logic [MEM_ADR_BITS-1:0] idx_s;
    logic [DATA_WIDTH-1:0]   fetch_s;
    logic                    wr_en_s;
    logic [MEM_ADR_BITS-1:0] wr_idx_s;

    // Next-state logic; a dropped request in any busy state returns straight to IDLE.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        beat_s   = beat_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_cc2mem) begin
                    accept_s = 1'b1;
                    beat_s   = {WORD_OFFSET{1'b0}};
                    if (LATENCY == 0) begin
                        state_s = ST_BEAT;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_cc2mem) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_s = ST_BEAT;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_BEAT: begin
                if (!req_cc2mem) begin
                    state_s = ST_IDLE;
                end else if (rdwr_r || (beat_r == LAST_BEAT)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!req_cc2mem) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BEAT;
                    beat_s  = beat_r + WORD_OFFSET'(1'b1);
                end
            end
            ST_DONE: begin
                if (!req_cc2mem) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Beat data is computed one edge early so outputs can be registered; with zero
    // latency the acceptance edge already loads beat 0 from the live request.
    always_comb begin
        rdwr_eff_s = accept_s ? rdwr_cc2mem : rdwr_r;
        adr_eff_s  = accept_s ? adr_cc2mem : adr_r;
        beat_adr_s = (adr_eff_s & LINE_MASK) | ADR_WIDTH'({beat_s, 2'b00});
        idx_s      = beat_adr_s[MEM_ADR_BITS+1:2];
        if (valid_r[idx_s]) begin
            fetch_s = ram_r[idx_s];
        end else begin
            fetch_s = DATA_WIDTH'(beat_adr_s) ^ SEED;
        end
        ack_s = (state_s == ST_BEAT);
        if (ack_s && !rdwr_eff_s) begin
            rdat_s = fetch_s;
        end else begin
            rdat_s = {DATA_WIDTH{1'b0}};
        end
        if (ack_s) begin
            word_s = beat_s;
        end else begin
            word_s = {WORD_OFFSET{1'b0}};
        end
        wr_en_s  = (state_r == ST_BEAT) && rdwr_r;
        wr_idx_s = adr_r[MEM_ADR_BITS+1:2];
    end

    // Control, latched request, registered outputs and per-word valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            beat_r  <= {WORD_OFFSET{1'b0}};
            adr_r   <= {ADR_WIDTH{1'b0}};
            rdwr_r  <= 1'b0;
            wdat_r  <= {DATA_WIDTH{1'b0}};
            ack_r   <= 1'b0;
            rdat_r  <= {DATA_WIDTH{1'b0}};
            word_r  <= {WORD_OFFSET{1'b0}};
            valid_r <= {DEPTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            beat_r  <= beat_s;
            ack_r   <= ack_s;
            rdat_r  <= rdat_s;
            word_r  <= word_s;
            if (accept_s) begin
                adr_r  <= adr_cc2mem;
                rdwr_r <= rdwr_cc2mem;
                wdat_r <= dat_cc2mem;
            end
            if (wr_en_s) begin
                valid_r[wr_idx_s] <= 1'b1;
            end
        end
    end

    // RAM array contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram_r[wr_idx_s] <= wdat_r;
        end
    end

    assign ack_mem2cc  = ack_r;
    assign dat_mem2cc  = rdat_r;
    assign word_mem2cc = word_r;

`ifdef MEM_PROTOCOL_CHECK_EN
    logic err_r;
    logic busy_s;

    assign busy_s = (state_r == ST_WAIT) || (state_r == ST_BEAT) || (state_r == ST_GAP);

    // Sticky flag for aborts and address changes during an accepted transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (busy_s && (!req_cc2mem || (adr_cc2mem != adr_r))) begin
            err_r <= 1'b1;
        end
    end

    assign err_mem2cc = err_r;
`else
    assign err_mem2cc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: bursts, writes, aliasing, abort,
// mid-burst reset, and a zero-latency seeded instance.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, rdwr;
    logic [31:0] adr, wdat;
    logic        ack, err;
    logic [31:0] rdat;
    logic [1:0]  word;

    logic        req0, rdwr0;
    logic [31:0] adr0, wdat0;
    logic        ack0, err0;
    logic [31:0] rdat0;
    logic [1:0]  word0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk(clk), .rst(rst),
        .req_cc2mem(req), .rdwr_cc2mem(rdwr), .adr_cc2mem(adr), .dat_cc2mem(wdat),
        .ack_mem2cc(ack), .dat_mem2cc(rdat), .word_mem2cc(word), .err_mem2cc(err)
    );

    mem_responder #(.LATENCY(0), .SEED(32'h0000_FFFF)) dut0 (
        .clk(clk), .rst(rst),
        .req_cc2mem(req0), .rdwr_cc2mem(rdwr0), .adr_cc2mem(adr0), .dat_cc2mem(wdat0),
        .ack_mem2cc(ack0), .dat_mem2cc(rdat0), .word_mem2cc(word0), .err_mem2cc(err0)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [31:0] a,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp_w [4];
        int first;
        int nack;
        exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
        first = -1;
        nack  = 0;
        req = 1'b1; rdwr = 1'b0; adr = a; wdat = 32'hDEAD_BEEF;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                rdwr = 1'b1;
                wdat = 32'h0BAD_F00D;
            end
            if (ack === 1'b1) begin
                if (first < 0) first = c;
                if (nack < 4) begin
                    check_val({tag, " data"}, rdat, exp_w[nack]);
                    check_val({tag, " word"}, 32'(word), 32'(nack));
                    check_val({tag, " spacing"}, 32'(c), 32'(first + 2 * nack));
                end
                nack++;
            end else begin
                check_val({tag, " quiet outputs"}, rdat | 32'(word), 32'h0000_0000);
            end
        end
        check_val({tag, " first ack cycle"}, 32'(first), 32'd3);
        check_val({tag, " ack count"}, 32'(nack), 32'd4);
        req = 1'b0;
        tick();
        check_val({tag, " ack after release"}, 32'(ack), 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        int first;
        int nack;
        first = -1;
        nack  = 0;
        req = 1'b1; rdwr = 1'b1; adr = a; wdat = d;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) wdat = 32'h1234_5678;
            if (ack === 1'b1) begin
                if (first < 0) first = c;
                check_val({tag, " data zero"}, rdat, 32'h0000_0000);
                nack++;
            end
        end
        check_val({tag, " first ack cycle"}, 32'(first), 32'd3);
        check_val({tag, " ack count"}, 32'(nack), 32'd1);
        req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        req = 1'b0; rdwr = 1'b0; adr = 32'h0; wdat = 32'h0;
        req0 = 1'b0; rdwr0 = 1'b0; adr0 = 32'h0; wdat0 = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        check_val("reset ack", 32'(ack), 32'd0);
        check_val("reset dat", rdat, 32'h0000_0000);
        check_val("reset word", 32'(word), 32'd0);
        check_val("reset err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        do_read("pattern read", 32'hFF07_BD08,
                32'hFF07_BD00, 32'hFF07_BD04, 32'hFF07_BD08, 32'hFF07_BD0C);
        do_write("write", 32'h5F57_ED08, 32'hAAAA_AAAA);
        do_read("read after write", 32'h5F57_ED00,
                32'h5F57_ED00, 32'h5F57_ED04, 32'hAAAA_AAAA, 32'h5F57_ED0C);
        do_read("alias read", 32'hFF07_BD08,
                32'hFF07_BD00, 32'hFF07_BD04, 32'hAAAA_AAAA, 32'hFF07_BD0C);

        // Abort after beat 1, then re-request at once to prove IDLE is reached next cycle.
        req = 1'b1; rdwr = 1'b0; adr = 32'h1234_5608;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 3) begin
                check_val("abort beat0 ack", 32'(ack), 32'd1);
                check_val("abort beat0 data", rdat, 32'h1234_5600);
            end
            if (c == 5) begin
                check_val("abort beat1 ack", 32'(ack), 32'd1);
                check_val("abort beat1 data", rdat, 32'h1234_5604);
            end
        end
        req = 1'b0;
        tick();
        check_val("abort no ack", 32'(ack), 32'd0);
`ifdef MEM_PROTOCOL_CHECK_EN
        check_val("abort err", 32'(err), 32'd1);
`else
        check_val("abort err", 32'(err), 32'd0);
`endif
        do_read("read after abort", 32'hFF07_BD00,
                32'hFF07_BD00, 32'hFF07_BD04, 32'hAAAA_AAAA, 32'hFF07_BD0C);

        // Reset in the middle of a burst.
        req = 1'b1; rdwr = 1'b0; adr = 32'h5F57_ED08;
        for (int c = 1; c <= 5; c++) tick();
        check_val("pre-reset ack", 32'(ack), 32'd1);
        rst = 1'b0;
        #1;
        check_val("mid-reset ack", 32'(ack), 32'd0);
        check_val("mid-reset dat", rdat, 32'h0000_0000);
        check_val("mid-reset word", 32'(word), 32'd0);
        check_val("mid-reset err", 32'(err), 32'd0);
        req = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        do_read("read after reset", 32'h5F57_ED08,
                32'h5F57_ED00, 32'h5F57_ED04, 32'h5F57_ED08, 32'h5F57_ED0C);

        // Zero-latency, seeded instance.
        req0 = 1'b1; rdwr0 = 1'b0; adr0 = 32'h0000_0010;
        tick();
        check_val("lat0 beat0 ack", 32'(ack0), 32'd1);
        check_val("lat0 beat0 data", rdat0, 32'h0000_FFEF);
        check_val("lat0 beat0 word", 32'(word0), 32'd0);
        tick();
        check_val("lat0 gap ack", 32'(ack0), 32'd0);
        tick();
        check_val("lat0 beat1 ack", 32'(ack0), 32'd1);
        check_val("lat0 beat1 data", rdat0, 32'h0000_FFEB);
        check_val("lat0 beat1 word", 32'(word0), 32'd1);
        req0 = 1'b0;
        tick();
        check_val("lat0 abort ack", 32'(ack0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cache controller's refill/write interface; the opposite end of req_cc2mem/adr_cc2mem/ack_mem2cc/dat_mem2cc.
- Serves line reads as 4-beat bursts (one ack pulse per word) and single-word writes.
- Backed by a small resettable-valid RAM; unwritten locations return a deterministic address pattern.
- Used as the memory model in cache-controller system benches and as the basis for the real memory front-end.

Parameters:
- ADR_WIDTH, 32, address width (byte address).
- DATA_WIDTH, 32, word width.
- WORD_OFFSET, 2, log2 words per line (4 beats).
- MEM_ADR_BITS, 6, log2 RAM depth in words (64).
- LATENCY, 2, idle cycles between request acceptance and first beat (0..15).
- SEED, 32'h0000_0000, XOR mask for pattern data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_cc2mem  in  1  request; held high by the cache controller until the transaction completes.
- rdwr_cc2mem  in  1  0 = line read, 1 = word write; sampled on acceptance.
- adr_cc2mem  in  ADR_WIDTH  byte address; sampled on acceptance.
- dat_cc2mem  in  DATA_WIDTH  write data; sampled on acceptance.
- ack_mem2cc  out  1  one-cycle pulse per beat.
- dat_mem2cc  out  DATA_WIDTH  read data, valid while ack_mem2cc=1.
- word_mem2cc  out  WORD_OFFSET  word index of the current beat (maps to word_mem2mshr).
- err_mem2cc  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; FSM to IDLE.
  - All RAM valid bits cleared; RAM data contents are not reset.
- FSM states: IDLE, WAIT, BEAT, GAP, DONE.
- IDLE: on req=1, latch rdwr, adr, and dat; latency counter = LATENCY; go to WAIT (or to BEAT if LATENCY=0).
- WAIT: decrement the counter; go to BEAT when it reaches 0.
- Latency rule: the first ack_mem2cc is high exactly LATENCY+1 cycles after the first cycle req is seen high in IDLE.
- Read bursts:
  - Line-aligned, word order 0,1,2,3, regardless of adr[WORD_OFFSET+1:2].
  - BEAT: ack=1, word_mem2cc=beat index, dat driven for one cycle.
  - GAP: ack=0 for exactly one cycle, then the next BEAT.
  - After beat 3: go to DONE (no GAP).
  - A burst is 7 cycles from the first ack to the last ack.
- Write: one BEAT cycle with ack=1 and dat_mem2cc=0; RAM[index] is written and its valid bit set at that edge; then DONE.
- DONE: ack=0; wait for req=0, then IDLE. A new request is never accepted in the same cycle req falls.
- Read data source:
  - index = word address bits [MEM_ADR_BITS+1:2].
  - If valid[index]: return RAM[index].
  - Else: return (line base | beat<<2) ^ SEED.
- Aliasing: addresses that share an index share a RAM entry; there is no tag check. This is a documented property.
- req falling in WAIT, BEAT, or GAP (abort): go to IDLE next cycle; no further acks; a write not yet acked is not performed.
- adr, rdwr, and dat changes after acceptance are ignored; latched values are used.
- dat_mem2cc and word_mem2cc are registered, and equal 0 when ack=0.

Optional Feature:
- Macro: MEM_PROTOCOL_CHECK_EN.
- Defined: err_mem2cc is set and held until reset on either condition:
  - req falls in WAIT/BEAT/GAP (abort);
  - adr_cc2mem differs from the latched address while the FSM is in WAIT, BEAT, or GAP.
- Defined: the abort behaviour itself is unchanged.
- Undefined: err_mem2cc is tied to 0 and no checking logic is present.

Test Plan:
- Read of 0xFF07BD08 after reset, LATENCY=2 -> ack first high 3 cycles after req; beats word 0..3 carry 0xFF07BD00, 0xFF07BD04, 0xFF07BD08, 0xFF07BD0C; ack alternates 1,0 with exactly 4 pulses; no accept until req falls.
- Write 0x5F57ED08 with 0xAAAAAAAA -> single ack pulse; then a read of 0x5F57ED00 returns beat2=0xAAAAAAAA and the other beats 0x5F57ED00/04/0C.
- Aliasing: after that write, a read of 0xFF07BD08 returns beat2=0xAAAAAAAA (index 2 shared).
- Abort: req dropped after beat 1 -> no further acks, FSM in IDLE next cycle; err_mem2cc=1 only with MEM_PROTOCOL_CHECK_EN defined.
- Reset asserted mid-burst -> ack and data go to 0 immediately; a subsequent read of 0x5F57ED08 returns pattern 0x5F57ED08 at beat2 (valid bits cleared).
- LATENCY=0 and SEED=0x0000FFFF -> ack in the first cycle after req is seen; beat0 of address 0x00000010 = 0x0000FFEF.
